mux_scan_n: RTL and testbench



---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_n_comb.sv | 24 ++
 rtl/mux_scan_n.sv | 175 +++++++++++++++++
 tb/tb_mux_scan_n.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_scan_n selector family.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    // Channels past the populated range read as this bit replicated across the width.
    localparam logic FILL_BIT = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational CHANNELS-to-1 selector; unpopulated select codes return all-ones.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS*BITS-1:0] data_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [BITS-1:0]          data_o
);

    always_comb begin
        // NOTE: default assigned before the loop so every path drives data_o (no latch).
        data_o = {BITS{FILL_BIT}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = data_i[k*BITS +: BITS];
            end
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel selector with valid/ready output, manual capture and auto-scan.
// Optional MUX_SCAN_MASK_EN adds chan_mask; scan then skips channels whose mask bit is 0.
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int  BITS     = 4,
    parameter int  CHANNELS = 8,
    parameter int  DWELL    = 4,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [CHANNELS*BITS-1:0] data_in,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     mode,
    input  logic                     load,
    input  logic                     enable,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]      chan_mask,
`endif
    input  logic                     out_ready,
    output logic [BITS-1:0]          out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    output logic                     wrap
);

    localparam int               DW_W      = sel_width(DWELL);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  DWELL_END = DW_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [BITS-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;

    logic             slot;
    logic             capture;
    logic [SEL_W-1:0] mux_sel;
    logic [BITS-1:0]  mux_data;
    logic [SEL_W-1:0] next_idx;
    logic             step_wraps;
    logic             scan_cap_ok;

    // A slot exists when the register is empty or is being drained this cycle.
    assign slot    = !out_valid_q || out_ready;
    assign mux_sel = (state_q == SCAN) ? scan_idx_q : sel_in;

    mux_n_comb #(
        .BITS     (BITS),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .data_i (data_in),
        .sel_i  (mux_sel),
        .data_o (mux_data)
    );

`ifdef MUX_SCAN_MASK_EN
    // Returns {wrapped, index} of the next enabled channel after idx, searching circularly.
    function automatic logic [SEL_W:0] next_enabled(input logic [SEL_W-1:0]    idx,
                                                    input logic [CHANNELS-1:0] mask);
        logic [SEL_W:0] res;
        logic           found;
        int             pos;
        res   = {1'b0, idx};
        found = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            pos = int'(idx) + k;
            if (!found && mask[pos % CHANNELS]) begin
                found = 1'b1;
                res   = {pos >= CHANNELS, SEL_W'(pos % CHANNELS)};
            end
        end
        return res;
    endfunction

    assign {step_wraps, next_idx} = next_enabled(scan_idx_q, chan_mask);
    assign scan_cap_ok            = chan_mask[scan_idx_q];
`else
    assign next_idx    = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + SEL_W'(1);
    assign step_wraps  = (scan_idx_q == LAST_IDX);
    assign scan_cap_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q && !out_ready;
        wrap_d      = 1'b0;
        scan_idx_d  = scan_idx_q;
        dwell_d     = dwell_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!mode && load) begin
                    capture = slot;
                    state_d = HOLD;
                end else if (mode && enable) begin
                    state_d = SCAN;
                    dwell_d = '0;
                end
            end
            HOLD: begin
                capture = load && slot;
                if (mode) begin
                    state_d = SCAN;
                    dwell_d = '0;
                end
            end
            SCAN: begin
                // Without a slot at the dwell boundary everything waits, so no channel is skipped.
                if (enable) begin
                    if (dwell_q != DWELL_END) begin
                        dwell_d = dwell_q + DW_W'(1);
                    end else if (slot) begin
                        capture    = scan_cap_ok;
                        dwell_d    = '0;
                        scan_idx_d = next_idx;
                        wrap_d     = step_wraps;
                    end
                end
                if (!mode) begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            out_data_d  = mux_data;
            out_sel_d   = mux_sel;
            out_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            scan_idx_q  <= '0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            scan_idx_q  <= scan_idx_d;
            dwell_q     <= dwell_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

    // A held, unconsumed value must not change until the consumer takes it.
    assert property (@(posedge clock) disable iff (!reset_n)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_sel_q)));

    assert property (@(posedge clock) disable iff (!reset_n)
        scan_idx_q <= LAST_IDX);

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: vector table for manual mode, scoreboard on consumed outputs,
// hand sequences for scan timing, backpressure, freeze and reset mid-scan.
module tb_mux_scan_n;

    localparam int BITS  = 4;
    localparam int CH    = 8;
    localparam int CH6   = 6;
    localparam int DWELL = 4;

    logic               clock     = 1'b0;
    logic               reset_n   = 1'b1;
    logic [CH*BITS-1:0] data_in   = 32'h8765_4321;
    logic [2:0]         sel_in    = 3'd0;
    logic               mode      = 1'b0;
    logic               load      = 1'b0;
    logic               enable    = 1'b0;
    logic               out_ready = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    logic [CH-1:0]      chan_mask = '1;
`endif

    logic [3:0] out_data;
    logic [2:0] out_sel;
    logic       out_valid;
    logic       wrap;
    logic [3:0] u6_data;
    logic [2:0] u6_sel;
    logic       u6_valid;
    logic       u6_wrap;

    mux_scan_n #(.BITS(BITS), .CHANNELS(CH), .DWELL(DWELL)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .mode      (mode),
        .load      (load),
        .enable    (enable),
`ifdef MUX_SCAN_MASK_EN
        .chan_mask (chan_mask),
`endif
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    mux_scan_n #(.BITS(BITS), .CHANNELS(CH6), .DWELL(DWELL)) u_dut6 (
        .clock     (clock),
        .reset_n   (reset_n),
        .data_in   (data_in[CH6*BITS-1:0]),
        .sel_in    (sel_in),
        .mode      (mode),
        .load      (load),
        .enable    (enable),
`ifdef MUX_SCAN_MASK_EN
        .chan_mask (chan_mask[CH6-1:0]),
`endif
        .out_ready (out_ready),
        .out_data  (u6_data),
        .out_sel   (u6_sel),
        .out_valid (u6_valid),
        .wrap      (u6_wrap)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] sel;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic       load;
        logic       rdy;
        logic [3:0] e_data;
        logic [2:0] e_sel;
        logic       e_valid;
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        logic [3:0] e6;
    } oor_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    oor_t oors[4];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;
    int   bad;
    bit   m_valid  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] ch_val(input logic [2:0] s);
        return 4'(s) + 4'd1;
    endfunction

    task automatic push_scan(input logic [2:0] idx);
        exp_q.push_back('{data: ch_val(idx), sel: idx});
    endtask

    task automatic drive_manual(input logic [2:0] s, input logic ld, input logic rdy);
        mode      = 1'b0;
        sel_in    = s;
        load      = ld;
        out_ready = rdy;
        if (ld && (!m_valid || rdy)) begin
            exp_q.push_back('{data: ch_val(s), sel: s});
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        step();
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < max_cyc);
        if (!out_valid) check("wait_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Consumer side of the scoreboard: every value taken by the consumer must match the queue head.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(e.data));
                check("sb_sel", 32'(out_sel), 32'(e.sel));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

`ifdef MUX_SCAN_MASK_EN
    logic [2:0] mseq [4] = '{3'd0, 3'd2, 3'd7, 3'd0};
    logic       mwrap[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif

    initial begin
        vecs[0] = '{3'd5, 1'b1, 1'b1, 4'h6, 3'd5, 1'b1};
        vecs[1] = '{3'd2, 1'b0, 1'b0, 4'h6, 3'd5, 1'b1};
        vecs[2] = '{3'd2, 1'b1, 1'b0, 4'h6, 3'd5, 1'b1};
        vecs[3] = '{3'd2, 1'b1, 1'b1, 4'h3, 3'd2, 1'b1};
        vecs[4] = '{3'd0, 1'b0, 1'b1, 4'h3, 3'd2, 1'b0};
        vecs[5] = '{3'd7, 1'b1, 1'b0, 4'h8, 3'd7, 1'b1};
        vecs[6] = '{3'd0, 1'b1, 1'b1, 4'h1, 3'd0, 1'b1};
        vecs[7] = '{3'd3, 1'b0, 1'b1, 4'h1, 3'd0, 1'b0};

        oors[0] = '{3'd7, 4'hF};
        oors[1] = '{3'd6, 4'hF};
        oors[2] = '{3'd5, 4'h6};
        oors[3] = '{3'd0, 4'h1};

        #2 reset_n = 1'b0;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sel", 32'(out_sel), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive_manual(vecs[i].sel, vecs[i].load, vecs[i].rdy);
            check($sformatf("man%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
            check($sformatf("man%0d_sel", i), 32'(out_sel), 32'(vecs[i].e_sel));
            check($sformatf("man%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
        end

        for (int i = 0; i < 4; i++) begin
            drive_manual(oors[i].sel, 1'b1, 1'b1);
            check($sformatf("oor%0d_data", i), 32'(u6_data), 32'(oors[i].e6));
            check($sformatf("oor%0d_sel", i), 32'(u6_sel), 32'(oors[i].sel));
            check($sformatf("oor%0d_valid", i), 32'(u6_valid), 32'd1);
        end
        check("oor_wrap", 32'(u6_wrap), 32'd0);
        drive_manual(3'd0, 1'b0, 1'b1);

        mode      = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        load      = 1'b0;
        push_scan(3'd0);
        wait_valid(16, cyc);
        check("scan0_sel", 32'(out_sel), 32'd0);
        check("scan0_wrap", 32'(wrap), 32'd0);
        bad = 0;
        for (int j = 1; j <= 10; j++) begin
            push_scan(3'(j % CH));
            for (int g = 0; g < DWELL - 1; g++) begin
                step();
                if (out_valid || wrap) bad++;
            end
            step();
            check($sformatf("scan%0d_valid", j), 32'(out_valid), 32'd1);
            check($sformatf("scan%0d_sel", j), 32'(out_sel), 32'(j % CH));
            check($sformatf("scan%0d_wrap", j), 32'(wrap), (j % CH == CH - 1) ? 32'd1 : 32'd0);
        end
        check("scan_gaps", 32'(bad), 32'd0);

        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("bp%0d_hold", c), 32'({out_valid, out_sel, out_data}),
                  32'({1'b1, 3'd2, 4'h3}));
        end
        push_scan(3'd3);
        out_ready = 1'b1;
        step();
        check("bp_release", 32'({out_valid, out_sel, out_data}), 32'({1'b1, 3'd3, 4'h4}));

        enable = 1'b0;
        bad    = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_valid) bad++;
        end
        check("freeze_no_capture", 32'(bad), 32'd0);

        out_ready = 1'b0;
        enable    = 1'b1;
        push_scan(3'd4);
        wait_valid(16, cyc);
        check("resume_latency", 32'(cyc), 32'd4);
        check("resume_sel", 32'(out_sel), 32'd4);

        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'd0);
        check("rst_mid_sel", 32'(out_sel), 32'd0);
        check("rst_mid_wrap", 32'(wrap), 32'd0);
        exp_q.delete();
        out_ready = 1'b1;
        step();
        reset_n = 1'b1;
        push_scan(3'd0);
        wait_valid(16, cyc);
        check("post_rst_latency", 32'(cyc), 32'd5);
        check("post_rst_sel", 32'(out_sel), 32'd0);
        check("post_rst_data", 32'(out_data), 32'd1);
        mode   = 1'b0;
        enable = 1'b0;
        step();
        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef MUX_SCAN_MASK_EN
        reset_n = 1'b0;
        step();
        chan_mask = 8'b1000_0101;
        reset_n   = 1'b1;
        mode      = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            push_scan(mseq[m]);
            wait_valid(16, cyc);
            check($sformatf("mask%0d_sel", m), 32'(out_sel), 32'(mseq[m]));
            check($sformatf("mask%0d_wrap", m), 32'(wrap), 32'(mwrap[m]));
        end
        mode   = 1'b0;
        enable = 1'b0;
        step();
        step();
        check("mask_sb_drained", 32'(exp_q.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
